// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD keypad/price-entry datapath.
package bcd_pkg;
  typedef enum logic {IDLE = 1'b0, CONV = 1'b1} state_t;

  localparam int         NDIG      = 4;
  localparam logic [3:0] BCD_MAX   = 4'd9;
  localparam int         BIN_W_MIN = 14;
endpackage

// File: rtl/bcd_mac10.sv
// One decimal accumulate step, acc*10 + digit, built from shifts and adds.
module bcd_mac10 #(
  parameter int W = 14
) (
  input  logic [W-1:0] acc_in,
  input  logic [3:0]   digit,
  output logic [W-1:0] acc_out,
  output logic         digit_bad
);
  import bcd_pkg::*;

  // Truncation to W only bites on invalid digits, whose result is thrown away.
  assign acc_out   = (acc_in << 3) + (acc_in << 1) + {{(W-4){1'b0}}, digit};
  assign digit_bad = (digit > BCD_MAX);
endmodule

// File: rtl/bcd_to_binary.sv
// Iterative 4-digit BCD to binary converter, one digit per clock, start/busy/done.
module bcd_to_binary #(
  parameter int BIN_W = 14,
  parameter int NDIG  = bcd_pkg::NDIG
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       thos,
  input  logic [3:0]       hund,
  input  logic [3:0]       tens,
  input  logic [3:0]       ones,
  output logic             busy,
  output logic             done,
  output logic [BIN_W-1:0] binary,
  output logic             err
);
  import bcd_pkg::*;

  localparam int                CNT_W    = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(NDIG - 1);

  state_t                  state, state_nxt;
  logic [NDIG-1:0][3:0]    dig_q;
  logic [BIN_W-1:0]        acc;
  logic [CNT_W-1:0]        cnt;
  logic                    err_int;
  logic [BIN_W-1:0]        mac_out;
  logic                    mac_bad;
  logic                    last;

  bcd_mac10 #(.W(BIN_W)) u_mac (
    .acc_in   (acc),
    .digit    (dig_q[NDIG-1]),
    .acc_out  (mac_out),
    .digit_bad(mac_bad)
  );

  assign last = (cnt == CNT_LAST);

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = CONV;
      CONV: begin
        busy = 1'b1;
        if (last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Thousands digit sits at the head of the shift register and is consumed first.
  always_ff @(posedge clk) begin
    if (reset) begin
      dig_q   <= '0;
      acc     <= '0;
      cnt     <= '0;
      err_int <= 1'b0;
      binary  <= '0;
      err     <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          dig_q   <= {thos, hund, tens, ones};
          acc     <= '0;
          cnt     <= '0;
          err_int <= 1'b0;
        end
        CONV: begin
          acc     <= mac_out;
          dig_q   <= {dig_q[NDIG-2:0], 4'h0};
          cnt     <= cnt + CNT_W'(1);
          err_int <= err_int | mac_bad;
          if (last) begin
            binary <= (err_int | mac_bad) ? '0 : mac_out;
            err    <= err_int | mac_bad;
            done   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_to_binary.sv
// Scoreboard bench: expected results queued at start, checked when done pulses.
module tb_bcd_to_binary;
  localparam int BIN_W = 14;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [3:0]       thos = '0, hund = '0, tens = '0, ones = '0;
  logic             busy, done, err;
  logic [BIN_W-1:0] binary;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic             err;
    logic [BIN_W-1:0] bin;
  } exp_t;

  exp_t exp_q[$];
  logic prev_done = 1'b0;

  bcd_to_binary #(.BIN_W(BIN_W), .NDIG(4)) dut (
    .clk(clk), .reset(reset), .start(start),
    .thos(thos), .hund(hund), .tens(tens), .ones(ones),
    .busy(busy), .done(done), .binary(binary), .err(err)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [15:0] digs);
    int   v;
    logic bad;
    exp_t e;
    v   = 0;
    bad = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      int d;
      d = int'(digs[i*4 +: 4]);
      if (d > 9) bad = 1'b1;
      v = v * 10 + d;
    end
    e.err = bad;
    e.bin = bad ? '0 : BIN_W'(v);
    return e;
  endfunction

  // Monitor: every done must match the oldest queued expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      exp_t e;
      tests++;
      if (prev_done === 1'b1) begin
        fails++;
        $display("FAIL done_consecutive: done high two cycles in a row");
      end
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_done: got binary=%0d err=%0b, none expected", binary, err);
      end else begin
        e = exp_q.pop_front();
        if (binary !== e.bin || err !== e.err) begin
          fails++;
          $display("FAIL result: got binary=%0d err=%0b, expected binary=%0d err=%0b",
                   binary, err, e.bin, e.err);
        end
      end
    end
    prev_done = done;
  end

  // Called at a negedge; returns at the negedge right after the start edge.
  task automatic kick(input logic [15:0] digs);
    start = 1'b1;
    {thos, hund, tens, ones} = digs;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    {thos, hund, tens, ones} = 16'hFFFF;
  endtask

  task automatic run_conv(input logic [15:0] digs, input string nm);
    int  busy_cyc;
    bit  got;
    exp_q.push_back(model(digs));
    kick(digs);
    busy_cyc = 0;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1) begin got = 1; break; end
      if (busy === 1'b1) busy_cyc++;
      @(negedge clk);
    end
    tests++;
    if (!got) begin
      fails++; $display("FAIL %s_timeout: no done within 20 cycles", nm);
    end
    tests++;
    if (busy_cyc != 4) begin
      fails++; $display("FAIL %s_busy_cycles: got %0d, expected 4", nm, busy_cyc);
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL %s_busy_at_done: got %b, expected 0", nm, busy);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    tests += 4;
    if (busy !== 1'b0)   begin fails++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    if (done !== 1'b0)   begin fails++; $display("FAIL reset_done: got %b, expected 0", done); end
    if (binary !== '0)   begin fails++; $display("FAIL reset_binary: got %0d, expected 0", binary); end
    if (err !== 1'b0)    begin fails++; $display("FAIL reset_err: got %b, expected 0", err); end
  endtask

  task automatic test_max;
    run_conv(16'h9999, "max");
  endtask

  task automatic test_hold;
    bit got;
    run_conv(16'h1234, "basic");
    @(negedge clk);
    exp_q.push_back(model(16'h0000));
    kick(16'h0000);
    got = 0;
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1) begin got = 1; break; end
      tests++;
      if (binary !== BIN_W'(1234)) begin
        fails++; $display("FAIL hold_binary: got %0d, expected 1234", binary);
      end
      @(negedge clk);
    end
    tests++;
    if (!got) begin fails++; $display("FAIL zero_timeout: no done within 20 cycles"); end
  endtask

  task automatic test_invalid;
    @(negedge clk);
    run_conv(16'h05A7, "invalid");
    @(negedge clk);
    run_conv(16'h0042, "after_invalid");
  endtask

  task automatic test_busy_start;
    @(negedge clk);
    exp_q.push_back(model(16'h5000));
    kick(16'h5000);
    start = 1'b1;
    {thos, hund, tens, ones} = 16'h1111;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++; $display("FAIL busy_start_pending: %0d results missing, expected 0", exp_q.size());
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL busy_start_idle: busy=%b, expected 0", busy);
    end
  endtask

  task automatic test_reset_abort;
    @(negedge clk);
    kick(16'h9876);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    tests += 4;
    if (busy !== 1'b0)  begin fails++; $display("FAIL abort_busy: got %b, expected 0", busy); end
    if (done !== 1'b0)  begin fails++; $display("FAIL abort_done: got %b, expected 0", done); end
    if (binary !== '0)  begin fails++; $display("FAIL abort_binary: got %0d, expected 0", binary); end
    if (err !== 1'b0)   begin fails++; $display("FAIL abort_err: got %b, expected 0", err); end
    repeat (8) @(negedge clk);
    run_conv(16'h9876, "after_abort");
  endtask

  task automatic test_back_to_back;
    int  gap;
    bit  got;
    @(negedge clk);
    exp_q.push_back(model(16'h0123));
    kick(16'h0123);
    got = 0;
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1) begin got = 1; break; end
      @(negedge clk);
    end
    tests++;
    if (!got) begin fails++; $display("FAIL b2b_first_timeout: no done within 20 cycles"); end
    exp_q.push_back(model(16'h3210));
    kick(16'h3210);
    gap = 1;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1) begin got = 1; break; end
      gap++;
      @(negedge clk);
    end
    tests++;
    if (!got || gap != 5) begin
      fails++; $display("FAIL b2b_gap: got %0d cycles (seen=%0b), expected 5", gap, got);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++; $display("FAIL final_pending: %0d results missing, expected 0", exp_q.size());
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_max();
    test_hold();
    test_invalid();
    test_busy_start();
    test_reset_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
